// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow controller and its timer.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME,
    PLAY,
    NEWBALL,
    OVER
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam int TIMER_W = 7;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register.
// When PONG_SCORE_SAT_EN is defined the score saturates at 99.
// Otherwise 99 + 1 wraps to 00.
// A clear request takes priority over an increment.
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output bcd_t d1,
  output bcd_t d0
);

  bcd_t d1_next;
  bcd_t d0_next;

  // Next BCD value for a single increment, including the carry and the 99 boundary
  always_comb begin
    d1_next = d1;
    d0_next = d0;
    if (d0 == 4'd9) begin
      d0_next = 4'd0;
      if (d1 == 4'd9) begin
`ifdef PONG_SCORE_SAT_EN
        d1_next = 4'd9;
        d0_next = 4'd9;
`else
        d1_next = 4'd0;
`endif
      end else begin
        d1_next = d1 + 4'd1;
      end
    end else begin
      d0_next = d0 + 4'd1;
    end
  end

  // Score register: reset and clear both return to 00, clear beats increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (clr) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (inc) begin
      d1 <= d1_next;
      d0 <= d0_next;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for pong.
// It sequences title, play, ball relaunch and game-over.
// It paces relaunch and game-over with the countdown timer.
// It keeps the balls-left count and the BCD score.
// Optional feature: PONG_SCORE_SAT_EN (score saturates at 99) lives in bcd_score_counter.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS_INIT = 3,
  parameter int BALL_W     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        btn,
  input  logic              hit,
  input  logic              miss,
  input  logic              timer_up,
  output logic              timer_start,
  output logic              gra_still,
  output logic              ball_reset,
  output logic [3:0]        score_d1,
  output logic [3:0]        score_d0,
  output logic [BALL_W-1:0] balls_left,
  output logic              show_title,
  output logic              show_over
);

  localparam logic [BALL_W-1:0] BALLS_FULL  = BALL_W'(BALLS_INIT);
  localparam logic [BALL_W-1:0] BALLS_FIRST = BALL_W'(BALLS_INIT - 1);
  localparam logic [BALL_W-1:0] BALLS_ONE   = BALL_W'(1);

  game_state_t       state;
  game_state_t       state_next;
  logic [BALL_W-1:0] balls_next;
  logic              btn_any;
  logic              btn_any_q;
  logic              btn_rise;
  logic              score_clr;
  logic              score_inc;

  assign btn_any  = |btn;
  assign btn_rise = btn_any & ~btn_any_q;

  // Button history, so only a fresh press can advance the game
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_any_q <= 1'b0;
    end else begin
      btn_any_q <= btn_any;
    end
  end

  // State and balls-left registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= NEWGAME;
      balls_left <= BALLS_FULL;
    end else begin
      state      <= state_next;
      balls_left <= balls_next;
    end
  end

  // Next-state, balls-left update, score control and Mealy pulse outputs
  always_comb begin
    state_next  = state;
    balls_next  = balls_left;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    timer_start = 1'b0;
    ball_reset  = 1'b0;
    gra_still   = 1'b1;
    show_title  = 1'b0;
    show_over   = 1'b0;
    case (state)
      NEWGAME: begin
        show_title = 1'b1;
        score_clr  = 1'b1;
        balls_next = BALLS_FULL;
        if (btn_rise) begin
          state_next = PLAY;
          balls_next = BALLS_FIRST;
          ball_reset = 1'b1;
        end
      end
      PLAY: begin
        gra_still = 1'b0;
        if (miss) begin
          timer_start = 1'b1;
          state_next  = (balls_left == '0) ? OVER : NEWBALL;
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer_up && btn_rise && (balls_left != '0)) begin
          state_next = PLAY;
          balls_next = balls_left - BALLS_ONE;
          ball_reset = 1'b1;
        end
      end
      OVER: begin
        show_over = 1'b1;
        if (timer_up) begin
          state_next = NEWGAME;
          score_clr  = 1'b1;
          balls_next = BALLS_FULL;
        end
      end
      default: begin
        state_next = NEWGAME;
      end
    endcase
    // A cycle under reset must never launch the timer or recentre the ball
    if (!reset_n) begin
      timer_start = 1'b0;
      ball_reset  = 1'b0;
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .d1      (score_d1),
    .d0      (score_d0)
  );

endmodule
